// File: rtl/tt_input_debounce.sv
// Input conditioning for the tile switch bank: synchroniser, per-bit debounce, edge pulses, and an event snapshot.
// Latency: an input that is held steady reaches sw_out/rise/fall at edge SYNC_STAGES+DEBOUNCE_CYCLES. The event updates on the same edge as the pulses.
// Backpressure: only one snapshot is held. A change that arrives while the snapshot is unaccepted overwrites it and sets the sticky evt_overrun.
module tt_input_debounce #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             evt_valid,
    output logic [WIDTH-1:0] evt_data,
    input  logic             evt_ready,
    output logic             evt_overrun
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  synced;

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] sw_q, sw_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    logic             change;
    logic             accept;
    logic             evt_valid_q, evt_valid_d;
    logic [WIDTH-1:0] evt_data_q, evt_data_d;
    logic             evt_overrun_q, evt_overrun_d;

    // Synchroniser chain. It runs regardless of ena, so the synced view stays current while the tile is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= sw_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Per-bit debounce.
    // A change is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
    // Any sample that agrees with the stable level restarts the count.
    always_comb begin
        sw_d   = sw_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ena) begin
                if (synced[i] == sw_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    sw_d[i]   = synced[i];
                    cnt_d[i]  = '0;
                    rise_d[i] = synced[i];
                    fall_d[i] = ~synced[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state and the registered edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sw_q   <= sw_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign change = |(rise_d | fall_d);
    assign accept = evt_valid_q & evt_ready;

    // Snapshot channel.
    // A new change always wins over an accept on the same edge.
    // Overrun is raised only when a pending, unaccepted snapshot is overwritten.
    always_comb begin
        evt_valid_d   = evt_valid_q;
        evt_data_d    = evt_data_q;
        evt_overrun_d = evt_overrun_q;
        if (change) begin
            evt_valid_d = 1'b1;
            evt_data_d  = sw_d;
            if (accept) begin
                evt_overrun_d = 1'b0;
            end else if (evt_valid_q) begin
                evt_overrun_d = 1'b1;
            end
        end else if (accept) begin
            evt_valid_d   = 1'b0;
            evt_overrun_d = 1'b0;
        end
    end

    // Snapshot registers. The handshake keeps working while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid_q   <= 1'b0;
            evt_data_q    <= '0;
            evt_overrun_q <= 1'b0;
        end else begin
            evt_valid_q   <= evt_valid_d;
            evt_data_q    <= evt_data_d;
            evt_overrun_q <= evt_overrun_d;
        end
    end

    assign sw_out      = sw_q;
    assign rise        = rise_q;
    assign fall        = fall_q;
    assign evt_valid   = evt_valid_q;
    assign evt_data    = evt_data_q;
    assign evt_overrun = evt_overrun_q;

endmodule

// File: tb/tb_tt_input_debounce.sv
// Directed bench for tt_input_debounce. Each stimulus step queues the output state expected at a given edge.
// A separate monitor compares the queued state against the DUT whenever a rise or fall pulse appears.
// Steady-state and handshake checks are made inline.
module tb_tt_input_debounce;

    localparam int LAT = 18;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] sw_in;
    logic [7:0] sw_out;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       evt_valid;
    logic [7:0] evt_data;
    logic       evt_ready;
    logic       evt_overrun;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

    typedef struct {
        int          edge_n;
        logic [33:0] outs;
    } exp_t;

    exp_t sb[$];

    tt_input_debounce #(
        .WIDTH          (8),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .sw_in      (sw_in),
        .sw_out     (sw_out),
        .rise       (rise),
        .fall       (fall),
        .evt_valid  (evt_valid),
        .evt_data   (evt_data),
        .evt_ready  (evt_ready),
        .evt_overrun(evt_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [33:0] pack(input logic [7:0] s, input logic [7:0] r, input logic [7:0] f,
                                         input logic v, input logic [7:0] d, input logic o);
        return {s, r, f, d, v, o};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int at_edge, input logic [7:0] s, input logic [7:0] r, input logic [7:0] f,
                        input logic v, input logic [7:0] d, input logic o);
        exp_t e;
        e.edge_n = at_edge;
        e.outs   = pack(s, r, f, v, d, o);
        sb.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Change sw_in now; the debounced result is expected LAT edges later.
    task automatic drive(input logic [7:0] v, input logic [7:0] s, input logic [7:0] r, input logic [7:0] f,
                         input logic ev, input logic [7:0] d, input logic o);
        sw_in = v;
        push(edge_cnt + LAT, s, r, f, ev, d, o);
    endtask

    // One-cycle accept pulse; afterwards the snapshot must be gone.
    task automatic accept_one(input string name);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        chk({name, "_valid"}, 64'(evt_valid), 64'd0);
        chk({name, "_ovr"}, 64'(evt_overrun), 64'd0);
    endtask

    // Monitor: every pulse must match the oldest queued expectation, in both timing and content.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && (rise | fall) != 8'h00) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: rise=%h fall=%h at edge %0d, expected no pulse", rise, fall, edge_cnt);
                end else begin
                    e = sb.pop_front();
                    chk("event_edge", 64'(edge_cnt), 64'(e.edge_n));
                    chk("event_outputs", 64'(pack(sw_out, rise, fall, evt_valid, evt_data, evt_overrun)), 64'(e.outs));
                end
            end
        end
    end

    initial begin
        int b;
        rst_n     = 1'b0;
        ena       = 1'b1;
        sw_in     = 8'h00;
        evt_ready = 1'b0;
        cycles(3);
        chk("reset_state", 64'(pack(sw_out, rise, fall, evt_valid, evt_data, evt_overrun)), 64'd0);
        rst_n = 1'b1;
        cycles(3);

        // 1: single bit rises
        drive(8'h01, 8'h01, 8'h01, 8'h00, 1'b1, 8'h01, 1'b0);
        cycles(20);
        chk("t1_level", 64'(sw_out), 64'h01);
        chk("t1_evt", 64'({evt_valid, evt_data}), 64'h101);
        accept_one("t1_accept");

        // 2: glitch restarts the count; the edge is timed from the last transition
        sw_in = 8'h09;
        cycles(10);
        sw_in = 8'h01;
        cycles(1);
        drive(8'h09, 8'h09, 8'h08, 8'h00, 1'b1, 8'h09, 1'b0);
        cycles(20);
        chk("t2_level", 64'(sw_out), 64'h09);
        accept_one("t2_accept");

        // Both bits fall together, each with its own pulse
        drive(8'h00, 8'h00, 8'h00, 8'h09, 1'b1, 8'h00, 1'b0);
        cycles(20);
        accept_one("fall_accept");

        // 3: overrun when the second change lands on an unaccepted snapshot
        drive(8'h02, 8'h02, 8'h02, 8'h00, 1'b1, 8'h02, 1'b0);
        cycles(20);
        drive(8'h06, 8'h06, 8'h04, 8'h00, 1'b1, 8'h06, 1'b1);
        cycles(20);
        chk("t3_held", 64'({evt_valid, evt_overrun, evt_data}), 64'h306);
        cycles(3);
        chk("t3_stable", 64'(evt_data), 64'h06);
        accept_one("t3_accept");

        // 4: accept coincides with a change, and a prior overrun is cleared
        drive(8'h07, 8'h07, 8'h01, 8'h00, 1'b1, 8'h07, 1'b0);
        cycles(20);
        drive(8'h05, 8'h05, 8'h00, 8'h02, 1'b1, 8'h05, 1'b1);
        cycles(20);
        drive(8'h04, 8'h04, 8'h00, 8'h01, 1'b1, 8'h04, 1'b0);
        cycles(17);
        evt_ready = 1'b1;
        cycles(1);
        evt_ready = 1'b0;
        chk("t4_same_edge", 64'({evt_valid, evt_overrun, evt_data}), 64'h204);
        cycles(2);
        accept_one("t4_accept");

        // 5: freeze with counter at 8, then resume and expect the update 8 edges later
        b = edge_cnt;
        sw_in = 8'h0C;
        cycles(10);
        ena = 1'b0;
        cycles(20);
        chk("t5_frozen", 64'({sw_out, rise}), 64'h0400);
        ena = 1'b1;
        push(b + 38, 8'h0C, 8'h08, 8'h00, 1'b1, 8'h0C, 1'b0);
        cycles(10);
        chk("t5_level", 64'(sw_out), 64'h0C);
        ena = 1'b0;
        accept_one("t5_accept_ena0");
        ena = 1'b1;

        // 6: asynchronous reset mid-count with a pending snapshot
        drive(8'h0D, 8'h0D, 8'h01, 8'h00, 1'b1, 8'h0D, 1'b0);
        cycles(20);
        sw_in = 8'h0F;
        cycles(5);
        #2 rst_n = 1'b0;
        #1 chk("t6_async_reset", 64'(pack(sw_out, rise, fall, evt_valid, evt_data, evt_overrun)), 64'd0);
        sw_in = 8'hFF;
        cycles(3);
        rst_n = 1'b1;
        push(edge_cnt + LAT, 8'hFF, 8'hFF, 8'h00, 1'b1, 8'hFF, 1'b0);
        cycles(17);
        chk("t6_before", 64'(sw_out), 64'h00);
        cycles(5);
        chk("t6_level", 64'({evt_valid, evt_data, sw_out}), 64'h1FFFF);

        cycles(5);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
